// File: rtl/piso_tx_scheduler_pkg.sv
// Shared types and helpers for the two-requester serial transmit scheduler.
package piso_tx_scheduler_pkg;

  // Two-state frame sequencer: waiting for a word, or shifting one out.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int NUM_REQ = 2;

  // Round-robin pick between two requesters. The result is only meaningful
  // when at least one valid bit is set; with both set, the requester that
  // did not win last time goes next.
  function automatic logic arb_pick(input logic [NUM_REQ-1:0] valid,
                                    input logic               last_grant);
    logic pick;
    case (valid)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last_grant;
      default: pick = 1'b0;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/piso_shifter.sv
// Parallel-load, MSB-first shift register. A load takes priority over a
// shift in the same cycle; zeros fill in from the LSB end.
module piso_shifter
  import piso_tx_scheduler_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] d,
  output logic             q_msb
);

  logic [WIDTH-1:0] q;

  // Shift register: synchronous active-low clear, load over shift.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift_en) begin
      q <= {q[WIDTH-2:0], 1'b0};
    end
  end

  assign q_msb = q[WIDTH-1];

endmodule

// File: rtl/piso_tx_scheduler.sv
// Shares one parallel-in/serial-out shifter between two word producers.
// A round-robin arbiter accepts one word at a time while idle, then the
// FSM shifts it out MSB-first with start/end strobes on the first/last bit.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no frame on the wire; arbiter offers ready to one requester
// ST_SHIFT | frame in progress; one bit per cycle, count = bit index
module piso_tx_scheduler
  import piso_tx_scheduler_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [WIDTH-1:0]   req_data0,
  input  logic [WIDTH-1:0]   req_data1,
  output logic [NUM_REQ-1:0] req_ready,
  output logic               serial_out,
  output logic               bit_valid,
  output logic               frame_start,
  output logic               frame_end,
  output logic               grant_id,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    count;
  logic             last_grant;
  logic             grant;
  logic             load;
  logic             shift_en;
  logic             q_msb;
  logic [WIDTH-1:0] load_data;

  // The granted word is muxed straight into the shifter's parallel input.
  assign load_data = grant ? req_data1 : req_data0;

  piso_shifter #(
    .WIDTH(WIDTH)
  ) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .shift_en(shift_en),
    .d       (load_data),
    .q_msb   (q_msb)
  );

  // State register; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, arbitration and frame strobes. Ready is offered only while
  // idle, so the transfer edge is simply "idle with any valid".
  always_comb begin
    state_next  = state;
    grant       = 1'b0;
    req_ready   = '0;
    load        = 1'b0;
    shift_en    = 1'b0;
    serial_out  = 1'b0;
    bit_valid   = 1'b0;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    busy        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|req_valid) begin
          grant            = arb_pick(req_valid, last_grant);
          req_ready[grant] = 1'b1;
          load             = 1'b1;
          state_next       = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy        = 1'b1;
        bit_valid   = 1'b1;
        serial_out  = q_msb;
        shift_en    = 1'b1;
        frame_start = (count == '0);
        frame_end   = (count == LAST_BIT);
        if (count == LAST_BIT) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Bit counter and grant bookkeeping. last_grant resets to 1 so the first
  // contended arbitration after reset favours requester 0. The counter
  // saturates at the last bit index and is cleared on the next load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count      <= '0;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
    end else if (load) begin
      count      <= '0;
      last_grant <= grant;
      grant_id   <= grant;
    end else if (shift_en && (count != LAST_BIT)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: tb/tb_piso_tx_scheduler.sv
// Directed bench for piso_tx_scheduler at WIDTH=4: a cycle table for the
// basic frame and contended-pair cases, plus hand sequences for round-robin,
// back-to-back frames, mid-frame reset and an idle stretch.
module tb_piso_tx_scheduler;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic [1:0]       req_valid;
  logic [WIDTH-1:0] req_data0;
  logic [WIDTH-1:0] req_data1;
  logic [1:0]       req_ready;
  logic             serial_out;
  logic             bit_valid;
  logic             frame_start;
  logic             frame_end;
  logic             grant_id;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;

  piso_tx_scheduler #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data0  (req_data0),
    .req_data1  (req_data1),
    .req_ready  (req_ready),
    .serial_out (serial_out),
    .bit_valid  (bit_valid),
    .frame_start(frame_start),
    .frame_end  (frame_end),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output bundle: {req_ready[1:0], serial_out, bit_valid, frame_start, frame_end, grant_id, busy}
  function automatic logic [7:0] outs();
    return {req_ready, serial_out, bit_valid, frame_start, frame_end, grant_id, busy};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs just after a falling edge, then settle 1 time unit so the
  // caller samples well away from the next rising edge.
  task automatic apply(input logic r, input logic [1:0] v,
                       input logic [3:0] d0, input logic [3:0] d1);
    @(negedge clk);
    rst       = r;
    req_valid = v;
    req_data0 = d0;
    req_data1 = d1;
    #1;
  endtask

  task automatic do_reset();
    apply(1'b0, 2'b00, 4'h0, 4'h0);
    apply(1'b0, 2'b00, 4'h0, 4'h0);
  endtask

  typedef struct {
    logic       r;
    logic [1:0] v;
    logic [3:0] d0;
    logic [3:0] d1;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[18];

  initial begin
    int frames;
    int bad;
    logic exp_bv;

    rst       = 1'b0;
    req_valid = 2'b00;
    req_data0 = '0;
    req_data1 = '0;

    // Table: test 1 (single requester, 1001) then reset and test 2 (both
    // valid, 1010 from req0 then 0110 from req1 after one idle cycle).
    vecs[0]  = '{1'b1, 2'b01, 4'b1001, 4'b0000, 8'b01_0000_00};
    vecs[1]  = '{1'b1, 2'b00, 4'b1001, 4'b0000, 8'b00_1110_01};
    vecs[2]  = '{1'b1, 2'b00, 4'b1001, 4'b0000, 8'b00_0100_01};
    vecs[3]  = '{1'b1, 2'b00, 4'b1001, 4'b0000, 8'b00_0100_01};
    vecs[4]  = '{1'b1, 2'b00, 4'b1001, 4'b0000, 8'b00_1101_01};
    vecs[5]  = '{1'b1, 2'b00, 4'b1001, 4'b0000, 8'b00_0000_00};
    vecs[6]  = '{1'b0, 2'b00, 4'b0000, 4'b0000, 8'b00_0000_00};
    vecs[7]  = '{1'b1, 2'b11, 4'b1010, 4'b0110, 8'b01_0000_00};
    vecs[8]  = '{1'b1, 2'b11, 4'b1010, 4'b0110, 8'b00_1110_01};
    vecs[9]  = '{1'b1, 2'b11, 4'b1010, 4'b0110, 8'b00_0100_01};
    vecs[10] = '{1'b1, 2'b11, 4'b1010, 4'b0110, 8'b00_1100_01};
    vecs[11] = '{1'b1, 2'b11, 4'b1010, 4'b0110, 8'b00_0101_01};
    vecs[12] = '{1'b1, 2'b11, 4'b1010, 4'b0110, 8'b10_0000_00};
    vecs[13] = '{1'b1, 2'b00, 4'b1010, 4'b0110, 8'b00_0110_11};
    vecs[14] = '{1'b1, 2'b00, 4'b1010, 4'b0110, 8'b00_1100_11};
    vecs[15] = '{1'b1, 2'b00, 4'b1010, 4'b0110, 8'b00_1100_11};
    vecs[16] = '{1'b1, 2'b00, 4'b1010, 4'b0110, 8'b00_0101_11};
    vecs[17] = '{1'b1, 2'b00, 4'b1010, 4'b0110, 8'b00_0000_10};

    do_reset();
    check("reset_outputs", 32'(outs()), 32'h00);

    for (int i = 0; i < 18; i++) begin
      apply(vecs[i].r, vecs[i].v, vecs[i].d0, vecs[i].d1);
      check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end

    // Test 3: both valid held for four frames; grants alternate from 0,
    // ready never both high and never high while busy.
    do_reset();
    frames = 0;
    bad    = 0;
    for (int c = 0; c < 40 && frames < 4; c++) begin
      apply(1'b1, 2'b11, 4'b1100, 4'b0011);
      if (req_ready == 2'b11) bad++;
      if (busy && req_ready != 2'b00) bad++;
      if (frame_start) begin
        check($sformatf("t3_grant%0d", frames), 32'(grant_id), 32'(frames % 2));
        check($sformatf("t3_msb%0d", frames), 32'(serial_out), 32'((frames % 2) == 0));
        frames++;
      end
    end
    check("t3_frames", 32'(frames), 32'd4);
    check("t3_ready_rule", 32'(bad), 32'd0);

    // Test 4: req1 alone held with 1111; bit_valid repeats 1111 0.
    do_reset();
    for (int k = 0; k < 15; k++) begin
      apply(1'b1, 2'b10, 4'b0000, 4'b1111);
      exp_bv = (k % 5) != 0;
      check($sformatf("t4_cyc%0d", k), 32'({req_ready, bit_valid, serial_out}),
            32'({(exp_bv ? 2'b00 : 2'b10), exp_bv, exp_bv}));
    end
    check("t4_grant_id", 32'(grant_id), 32'd1);

    // Test 5: reset during the second bit of 1001, then a clean contended restart.
    do_reset();
    apply(1'b1, 2'b01, 4'b1001, 4'b0000);
    check("t5_accept", 32'(outs()), 32'(8'b01_0000_00));
    apply(1'b1, 2'b00, 4'b1001, 4'b0000);
    check("t5_bit0", 32'(outs()), 32'(8'b00_1110_01));
    apply(1'b0, 2'b00, 4'b1001, 4'b0000);
    check("t5_bit1", 32'(outs()), 32'(8'b00_0100_01));
    apply(1'b0, 2'b00, 4'b1001, 4'b0000);
    check("t5_aborted", 32'(outs()), 32'h00);
    apply(1'b1, 2'b11, 4'b1100, 4'b0011);
    check("t5_regrant", 32'(outs()), 32'(8'b01_0000_00));
    apply(1'b1, 2'b00, 4'b1100, 4'b0011);
    check("t5_new_b0", 32'(outs()), 32'(8'b00_1110_01));
    apply(1'b1, 2'b00, 4'b1100, 4'b0011);
    check("t5_new_b1", 32'(outs()), 32'(8'b00_1100_01));
    apply(1'b1, 2'b00, 4'b1100, 4'b0011);
    check("t5_new_b2", 32'(outs()), 32'(8'b00_0100_01));
    apply(1'b1, 2'b00, 4'b1100, 4'b0011);
    check("t5_new_b3", 32'(outs()), 32'(8'b00_0101_01));

    // Test 6: ten idle cycles after reset, everything quiet.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      apply(1'b1, 2'b00, 4'b1111, 4'b1111);
      check($sformatf("t6_idle%0d", k), 32'({busy, bit_valid, serial_out, req_ready}), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
